fsm_steer: RTL

//  Initiator-side companion for the 5-state one-hot FSM (C1,N7,C2,G1,E0; inputs a2,i2; outputs o3,u8,U6,U9).

---
 rtl/fsm_steer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fsm_steer.sv
// Initiator-side steering companion for the five-state C1/N7/C2/G1/E0 FSM.
// Drives a2/i2 along the shortest path to a requested state and checks the FSM's outputs against a shadow copy.
module fsm_steer #(
  parameter int MAX_STEPS = 4,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_target,
  output logic              i2,
  output logic              a2,
  input  logic              obs_o3,
  input  logic              obs_u8,
  input  logic              obs_U6,
  input  logic              obs_U9,
  output logic              done,
  output logic [1:0]        status,
  output logic [STEP_W-1:0] steps,
  output logic              err_mismatch
);

  typedef enum logic [2:0] {
    S_C1 = 3'd0,
    S_N7 = 3'd1,
    S_C2 = 3'd2,
    S_G1 = 3'd3,
    S_E0 = 3'd4
  } fsm_state_t;

  typedef enum logic [1:0] {
    CTL_IDLE   = 2'd0,
    CTL_STEER  = 2'd1,
    CTL_REPORT = 2'd2
  } ctl_state_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_UNREACH  = 2'b01,
    ST_MISMATCH = 2'b10,
    ST_TIMEOUT  = 2'b11
  } status_t;

  localparam logic [1:0] IDLE_DRIVE = 2'b10;

  // Transition function of the steered FSM, indexed by {i2,a2}.
  function automatic fsm_state_t fsm_next(input fsm_state_t s, input logic in_i2, input logic in_a2);
    case (s)
      S_C1:    fsm_next = (!in_i2) ? S_N7 : (in_a2 ? S_C2 : S_C1);
      S_N7:    fsm_next = (in_i2 || !in_a2) ? S_C2 : S_G1;
      S_C2:    fsm_next = (in_i2 && !in_a2) ? S_G1 : S_E0;
      S_G1:    fsm_next = S_N7;
      S_E0:    fsm_next = S_E0;
      default: fsm_next = S_C1;
    endcase
  endfunction

  // Moore outputs {o3,u8,U6,U9} expected in each state.
  function automatic logic [3:0] fsm_enc(input fsm_state_t s);
    case (s)
      S_C1:    fsm_enc = 4'b1000;
      S_N7:    fsm_enc = 4'b0000;
      S_C2:    fsm_enc = 4'b1111;
      S_G1:    fsm_enc = 4'b0110;
      S_E0:    fsm_enc = 4'b0011;
      default: fsm_enc = 4'b0000;
    endcase
  endfunction

  // First {i2,a2} step of the shortest path from s toward target t.
  function automatic logic [1:0] path_drive(input fsm_state_t s, input logic [2:0] t);
    path_drive = IDLE_DRIVE;
    if (t != 3'(s)) begin
      case (s)
        S_C1: begin
          if (t == 3'(S_N7))
            path_drive = 2'b00;
          else if (t == 3'(S_C2) || t == 3'(S_G1) || t == 3'(S_E0))
            path_drive = 2'b11;
        end
        S_N7: begin
          if (t == 3'(S_C2) || t == 3'(S_E0))
            path_drive = 2'b00;
          else if (t == 3'(S_G1))
            path_drive = 2'b01;
        end
        S_C2: begin
          if (t == 3'(S_E0))
            path_drive = 2'b00;
        end
        default: path_drive = IDLE_DRIVE;
      endcase
    end
  endfunction

  ctl_state_t        ctl, ctl_next;
  fsm_state_t        sh, sh_next;
  logic [2:0]        tgt, tgt_next;
  logic [STEP_W-1:0] steps_next;
  status_t           status_q, status_next;
  logic [1:0]        drive_next;
  logic [3:0]        obs_vec;
  logic              obs_bad;
  logic              unreach;

  assign obs_vec   = {obs_o3, obs_u8, obs_U6, obs_U9};
  assign obs_bad   = (obs_vec != fsm_enc(sh));
  assign unreach   = (tgt > 3'(S_E0))
                  || (tgt == 3'(S_C1) && sh != S_C1)
                  || (sh == S_E0 && tgt != 3'(S_E0));
  assign req_ready = (ctl == CTL_IDLE);
  assign done      = (ctl == CTL_REPORT);
  assign status    = status_q;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    ctl_next    = ctl;
    tgt_next    = tgt;
    steps_next  = steps;
    status_next = status_q;
    sh_next     = fsm_next(sh, i2, a2);

    case (ctl)
      CTL_IDLE: begin
        if (req_valid) begin
          ctl_next   = CTL_STEER;
          tgt_next   = req_target;
          steps_next = '0;
        end
      end
      CTL_STEER: begin
        if (obs_bad) begin
          ctl_next    = CTL_REPORT;
          status_next = ST_MISMATCH;
        end else if (tgt == 3'(sh)) begin
          ctl_next    = CTL_REPORT;
          status_next = ST_OK;
        end else if (unreach) begin
          ctl_next    = CTL_REPORT;
          status_next = ST_UNREACH;
        end else if (steps == STEP_W'(MAX_STEPS)) begin
          ctl_next    = CTL_REPORT;
          status_next = ST_TIMEOUT;
        end else begin
          steps_next  = steps + STEP_W'(1);
        end
      end
      CTL_REPORT: ctl_next = CTL_IDLE;
      default:    ctl_next = CTL_IDLE;
    endcase

    // The drive is computed against the state the FSM will hold after this edge.
    drive_next = (ctl_next == CTL_STEER) ? path_drive(sh_next, tgt_next) : IDLE_DRIVE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl          <= CTL_IDLE;
      sh           <= S_C1;
      tgt          <= '0;
      steps        <= '0;
      status_q     <= ST_OK;
      {i2, a2}     <= IDLE_DRIVE;
      err_mismatch <= 1'b0;
    end else begin
      ctl          <= ctl_next;
      sh           <= sh_next;
      tgt          <= tgt_next;
      steps        <= steps_next;
      status_q     <= status_next;
      {i2, a2}     <= drive_next;
      err_mismatch <= err_mismatch | obs_bad;
    end
  end

endmodule
